// File: rtl/stretch_recv_pkg.sv
// Shared definitions for the stretch_recv crossing receiver: FSM encoding and
// elaboration-time parameter legality.
package stretch_recv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HELD = 2'd2
  } state_e;

  function automatic bit params_legal(input int sync_stages, input int min_high,
                                      input int cnt_w);
    return (sync_stages >= 2) && (min_high >= 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/stretch_recv_if.sv
// Bundle of the stretch receiver's level input, counter clear, pulse output,
// acknowledge and counters.
interface stretch_recv_if #(
  parameter int CNT_W = 8
);
  logic             in;
  logic             clr;
  logic             out;
  logic             ack;
  logic [CNT_W-1:0] pulse_count;
  logic [CNT_W-1:0] glitch_count;

  modport master (output in, clr, input out, ack, pulse_count, glitch_count);
  modport slave  (input in, clr, output out, ack, pulse_count, glitch_count);
endinterface

// File: rtl/stretch_recv_sync_n.sv
// Generic N-flop level synchronizer with asynchronous active-low reset.
module sync_n #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] chain_q;
  logic [N-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  end

  assign q = chain_q[N-1];
endmodule

// File: rtl/stretch_recv.sv
// Receive end of the pulse-stretch crossing: synchronizes the stretched level,
// qualifies its high time and emits one pulse per accepted stretch.
module stretch_recv
  import stretch_recv_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  stretch_recv_if.slave  bus
);
  localparam int               QW      = (MIN_HIGH > 1) ? $clog2(MIN_HIGH) : 1;
  localparam logic [QW-1:0]    QLAST   = QW'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!params_legal(SYNC_STAGES, MIN_HIGH, CNT_W)) begin : g_illegal
    $error("stretch_recv: illegal SYNC_STAGES, MIN_HIGH or CNT_W");
  end

  logic s;

  sync_n #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (bus.in),
    .q     (s)
  );

  state_e           state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic             out_q, out_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    out_d   = 1'b0;
    pcnt_d  = pcnt_q;
    gcnt_d  = gcnt_q;

    unique case (state_q)
      IDLE: begin
        if (s) begin
          if (MIN_HIGH == 1) begin
            state_d = HELD;
            out_d   = 1'b1;
          end else begin
            state_d = QUAL;
            qcnt_d  = QW'(1);
          end
        end
      end
      QUAL: begin
        if (!s) begin
          state_d = IDLE;
          if (gcnt_q != CNT_MAX) gcnt_d = gcnt_q + 1'b1;
        end else if (qcnt_q == QLAST) begin
          state_d = HELD;
          out_d   = 1'b1;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      HELD: begin
        // The falling edge only re-arms; it never produces a pulse.
        if (!s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (out_d) pcnt_d = pcnt_q + 1'b1;
    if (bus.clr) begin
      pcnt_d = '0;
      gcnt_d = '0;
    end

    ack_d = (state_d == HELD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
      out_q   <= 1'b0;
      ack_q   <= 1'b0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.ack          = ack_q;
  assign bus.pulse_count  = pcnt_q;
  assign bus.glitch_count = gcnt_q;
endmodule

// File: tb/tb_stretch_recv.sv
// Scoreboard bench for stretch_recv: stimulus queues expected pulses, monitors
// pop them when out is seen high; counters and ack are checked directly.
`timescale 1ns/1ps
module tb_stretch_recv;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  stretch_recv_if #(.CNT_W(CNT_W)) bus  ();
  stretch_recv_if #(.CNT_W(CNT_W)) bus1 ();

  stretch_recv #(.SYNC_STAGES(2), .MIN_HIGH(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  stretch_recv #(.SYNC_STAGES(2), .MIN_HIGH(1), .CNT_W(CNT_W)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    int cyc;
    int pcnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  int checks   = 0;
  int failures = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push0(input int c, input int p);
    exp_t e;
    e.cyc  = c;
    e.pcnt = p;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input int p);
    exp_t e;
    e.cyc  = c;
    e.pcnt = p;
    q1.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.out === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL dut_pulse: unexpected out at cycle %0d", cyc);
      end else begin
        m0 = q0.pop_front();
        if (m0.cyc != cyc || m0.pcnt != int'(bus.pulse_count)) begin
          failures++;
          $display("FAIL dut_pulse: got cycle %0d count %0d, expected cycle %0d count %0d",
                   cyc, bus.pulse_count, m0.cyc, m0.pcnt);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.out === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL dut1_pulse: unexpected out at cycle %0d", cyc);
      end else begin
        m1 = q1.pop_front();
        if (m1.cyc != cyc || m1.pcnt != int'(bus1.pulse_count)) begin
          failures++;
          $display("FAIL dut1_pulse: got cycle %0d count %0d, expected cycle %0d count %0d",
                   cyc, bus1.pulse_count, m1.cyc, m1.pcnt);
        end
      end
    end
  end

  initial begin
    int e0;
    int r0;
    reset    = 1'b0;
    bus.in   = 1'b0;
    bus.clr  = 1'b0;
    bus1.in  = 1'b0;
    bus1.clr = 1'b0;

    // Reset held while in toggles: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.in = ~bus.in;
      check("rst_out", 32'(bus.out), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_pcnt", 32'(bus.pulse_count), 0);
      check("rst_gcnt", 32'(bus.glitch_count), 0);
    end
    bus.in = 1'b0;
    reset  = 1'b1;
    tick();
    check("rel_out", 32'(bus.out), 0);
    check("rel_ack", 32'(bus.ack), 0);
    check("rel_pcnt", 32'(bus.pulse_count), 0);
    check("rel_gcnt", 32'(bus.glitch_count), 0);

    // Six-cycle stretch: pulse at edge 4, ack until 3 edges after the fall.
    e0 = cyc;
    push0(e0 + 4, 1);
    bus.in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("t2_ack_rise", 32'(bus.ack), (i >= 4) ? 1 : 0);
    end
    bus.in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t2_ack_fall", 32'(bus.ack), (i <= 2) ? 1 : 0);
    end
    check("t2_pcnt", 32'(bus.pulse_count), 1);
    check("t2_gcnt", 32'(bus.glitch_count), 0);

    // One-cycle high is rejected as a glitch.
    bus.in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) bus.in = 1'b0;
      check("t3_gcnt", 32'(bus.glitch_count), (i == 4) ? 1 : 0);
      check("t3_ack", 32'(bus.ack), 0);
    end
    tick(3);
    check("t3_pcnt", 32'(bus.pulse_count), 1);

    // Clear, then wrap pulse_count and saturate glitch_count.
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("t4_clr_pcnt", 32'(bus.pulse_count), 0);
    check("t4_clr_gcnt", 32'(bus.glitch_count), 0);
    for (int k = 0; k < 300; k++) begin
      push0(cyc + 4, (k + 1) % 256);
      bus.in = 1'b1;
      tick(4);
      bus.in = 1'b0;
      tick(4);
    end
    check("t4_pcnt_wrap", 32'(bus.pulse_count), 44);
    for (int k = 0; k < 260; k++) begin
      bus.in = 1'b1;
      tick(1);
      bus.in = 1'b0;
      tick(4);
    end
    check("t4_gcnt_sat", 32'(bus.glitch_count), 255);
    check("t4_pcnt_hold", 32'(bus.pulse_count), 44);

    // Reset while the pulse is up and in stays high: re-qualified afterwards.
    e0 = cyc;
    bus.in = 1'b1;
    tick(4);
    check("t5_out_pre", 32'(bus.out), 1);
    check("t5_ack_pre", 32'(bus.ack), 1);
    #1 reset = 1'b0;
    #1;
    check("t5_out_async", 32'(bus.out), 0);
    check("t5_ack_async", 32'(bus.ack), 0);
    check("t5_pcnt_async", 32'(bus.pulse_count), 0);
    tick(2);
    reset = 1'b1;
    r0 = cyc;
    push0(r0 + 4, 1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("t5_ack_req", 32'(bus.ack), (i >= 4) ? 1 : 0);
    end
    check("t5_pcnt", 32'(bus.pulse_count), 1);
    bus.in = 1'b0;
    tick(4);

    // Bring pulse_count to 5, then clear on the edge that asserts out.
    for (int k = 0; k < 4; k++) begin
      push0(cyc + 4, 2 + k);
      bus.in = 1'b1;
      tick(4);
      bus.in = 1'b0;
      tick(4);
    end
    check("t6_pcnt5", 32'(bus.pulse_count), 5);
    e0 = cyc;
    push0(e0 + 4, 0);
    bus.in = 1'b1;
    tick(3);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    bus.in  = 1'b0;
    check("t6_clr_wins", 32'(bus.pulse_count), 0);
    tick(4);
    check("t6_pcnt_after", 32'(bus.pulse_count), 0);
    check("t6_gcnt", 32'(bus.glitch_count), 0);

    // MIN_HIGH=1: a single high cycle pulses at edge 3 with no glitch.
    e0 = cyc;
    push1(e0 + 3, 1);
    bus1.in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) bus1.in = 1'b0;
      check("t6b_gcnt", 32'(bus1.glitch_count), 0);
      check("t6b_ack", 32'(bus1.ack), (i == 3) ? 1 : 0);
    end
    check("t6b_pcnt", 32'(bus1.pulse_count), 1);

    tick(2);
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
